// File: rtl/draw_sequencer.sv
// draw_sequencer
//   Owns the single VGA plot port and runs up to three drawing engines in
//   fixed order (slot 0 fillscreen, slot 1 circle, slot 2 reuleaux). Each
//   enabled engine is started with a level start/done handshake, and only
//   the active engine's pixel stream is forwarded to the vga_adapter.
//
// Ports
//   clk          system clock (CLOCK_50 domain)
//   rst          asynchronous, active-high reset
//   start        level request to run the sequence; held until done is seen
//   eng_en       per-slot enable mask, latched when a sequence starts
//   done         sequence complete; held while start stays high
//   eng_start    one-hot start to the engines
//   eng_done     per-engine done
//   eng_x/eng_y/eng_colour/eng_plot  packed per-slot pixel streams
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel stream to vga_adapter
//   err          watchdog abort flag
//
// Build option
//   DRAW_SEQ_WDOG_EN  adds a per-engine run watchdog of WDOG_LIMIT cycles.
//                     When undefined, err is tied low and RUN waits forever.

`timescale 1ns/1ps

module draw_sequencer #(
    parameter int NUM_ENG    = 3,
    parameter int WDOG_LIMIT = 40000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_ENG-1:0]     eng_en,
    output logic                   done,
    output logic [NUM_ENG-1:0]     eng_start,
    input  logic [NUM_ENG-1:0]     eng_done,
    input  logic [8*NUM_ENG-1:0]   eng_x,
    input  logic [7*NUM_ENG-1:0]   eng_y,
    input  logic [3*NUM_ENG-1:0]   eng_colour,
    input  logic [NUM_ENG-1:0]     eng_plot,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   err
);

    // state     | meaning
    // ----------+---------------------------------------------------------
    // S_IDLE    | waiting for start; mask and first slot chosen on start
    // S_LAUNCH  | raise eng_start for slot idx
    // S_RUN     | engine idx drawing; its pixels reach the adapter
    // S_RELEASE | start dropped, waiting for engine idx to drop done
    // S_DONE    | all enabled slots finished; done held until start drops
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_RELEASE,
        S_DONE
    } state_t;

    if (NUM_ENG != 3) begin : g_num_eng_check
        $error("draw_sequencer supports NUM_ENG = 3 only");
    end
    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 65535) begin : g_wdog_check
        $error("draw_sequencer WDOG_LIMIT must fit a 16-bit counter");
    end

    state_t               state;
    logic [1:0]           idx;
    logic [NUM_ENG-1:0]   mask;

    logic [7:0]           sel_x;
    logic [6:0]           sel_y;
    logic [2:0]           sel_colour;
    logic                 sel_plot;
    logic                 sel_done;
    logic [2:0]           first_slot;
    logic [2:0]           next_slot;

`ifdef DRAW_SEQ_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
    logic [15:0]          wdog;
    logic                 err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Returns {found, slot}: lowest enabled slot at or above lo.
    function automatic logic [2:0] find_slot(input logic [NUM_ENG-1:0] m,
                                             input int lo);
        find_slot = 3'b000;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                find_slot = {1'b1, 2'(i)};
            end
        end
    endfunction

    always_comb begin
        sel_x      = eng_x[7:0];
        sel_y      = eng_y[6:0];
        sel_colour = eng_colour[2:0];
        case (idx)
            2'd1: begin
                sel_x      = eng_x[15:8];
                sel_y      = eng_y[13:7];
                sel_colour = eng_colour[5:3];
            end
            2'd2: begin
                sel_x      = eng_x[23:16];
                sel_y      = eng_y[20:14];
                sel_colour = eng_colour[8:6];
            end
            default: ;
        endcase
    end

    assign sel_plot   = eng_plot[idx];
    assign sel_done   = eng_done[idx];
    assign first_slot = find_slot(eng_en, 0);
    assign next_slot  = find_slot(mask, int'(idx) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            mask       <= '0;
            done       <= 1'b0;
            eng_start  <= '0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
`ifdef DRAW_SEQ_WDOG_EN
            wdog       <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Pixel path follows idx every cycle; only the plot strobe is
            // gated so an idle or finished engine cannot write the frame.
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= sel_plot && (state == S_RUN || state == S_RELEASE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask <= eng_en;
`ifdef DRAW_SEQ_WDOG_EN
                        err_q <= 1'b0;
`endif
                        if (first_slot[2]) begin
                            idx   <= first_slot[1:0];
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_LAUNCH: begin
                    eng_start <= NUM_ENG'(1) << idx;
`ifdef DRAW_SEQ_WDOG_EN
                    wdog      <= 16'd0;
`endif
                    state     <= S_RUN;
                end

                S_RUN: begin
                    if (sel_done) begin
                        eng_start <= '0;
                        state     <= S_RELEASE;
                    end
`ifdef DRAW_SEQ_WDOG_EN
                    // Hung engine: abandon it exactly as if it had finished.
                    else if (wdog == WDOG_LAST) begin
                        err_q     <= 1'b1;
                        eng_start <= '0;
                        state     <= S_RELEASE;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end

                S_RELEASE: begin
                    if (!sel_done) begin
                        if (next_slot[2]) begin
                            idx   <= next_slot[1:0];
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // done is raised for at least one cycle even if start
                    // already dropped during the run.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
`timescale 1ns/1ps

module tb_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  eng_en = 3'b000;
    logic        done;
    logic [2:0]  eng_start;
    logic [2:0]  eng_done;
    logic [23:0] eng_x = '0;
    logic [20:0] eng_y = '0;
    logic [8:0]  eng_colour = '0;
    logic [2:0]  eng_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        err;

    logic [2:0]  tb_done = 3'b000;
    logic [2:0]  tb_plot = 3'b000;
    logic        use_beh = 1'b0;
    logic [2:0]  beh_done;
    logic [2:0]  beh_plot;

    int errors = 0;
    int checks = 0;

    assign eng_done = use_beh ? beh_done : tb_done;
    assign eng_plot = use_beh ? beh_plot : tb_plot;

    always #5 clk = ~clk;

    draw_sequencer #(.NUM_ENG(3), .WDOG_LIMIT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .eng_en     (eng_en),
        .done       (done),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural engines: run dur[i] cycles after start, plot every 4th cycle.
    int bcnt [3];
    int dur  [3] = '{19200, 50, 80};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || !eng_start[i]) begin
                bcnt[i]     <= 0;
                beh_done[i] <= 1'b0;
                beh_plot[i] <= 1'b0;
            end else if (bcnt[i] == dur[i]) begin
                beh_done[i] <= 1'b1;
                beh_plot[i] <= 1'b0;
            end else begin
                bcnt[i]     <= bcnt[i] + 1;
                beh_plot[i] <= (bcnt[i] % 4 == 0);
            end
        end
    end

    // Monitor: plot count, launch order, done-fall to start-rise gap.
    int         cyc = 0;
    int         vga_cnt = 0;
    int         last_fall = 0;
    logic       mon_on = 1'b0;
    logic [2:0] prev_start = 3'b000;
    logic [2:0] prev_done = 3'b000;
    logic [2:0] rises [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) vga_cnt <= 0;
        else     vga_cnt <= vga_cnt + int'(vga_plot);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if ((prev_done & ~eng_done) != 3'b000) last_fall <= cyc;
            if (prev_start == 3'b000 && eng_start != 3'b000) begin
                if (rises.size() > 0) chk("start_gap", cyc - last_fall, 2);
                rises.push_back(eng_start);
            end
        end
        prev_start <= eng_start;
        prev_done  <= eng_done;
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        eng_en = 3'b000;
        tb_done = 3'b000;
        tb_plot = 3'b000;
        use_beh = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_est(input logic [2:0] want, input int budget, input string name);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(posedge clk);
            #1;
            if (eng_start == want) found = 1'b1;
        end
        chk(name, 32'(found), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_est"},   32'(eng_start),  0);
        chk({tag, "_done"},  32'(done),       0);
        chk({tag, "_plot"},  32'(vga_plot),   0);
        chk({tag, "_x"},     32'(vga_x),      0);
        chk({tag, "_y"},     32'(vga_y),      0);
        chk({tag, "_col"},   32'(vga_colour), 0);
        chk({tag, "_err"},   32'(err),        0);
    endtask

    typedef struct {
        logic        start;
        logic [2:0]  en;
        logic [2:0]  edn;
        logic [2:0]  epl;
        logic [23:0] ex;
        logic [20:0] ey;
        logic [8:0]  ec;
        logic [2:0]  x_est;
        logic        x_done;
        logic        x_plot;
        logic [7:0]  x_vx;
        logic [6:0]  x_vy;
        logic [2:0]  x_vc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [23:0] xa, xb;
        logic [20:0] yb;
        logic [8:0]  cb;
        bit          found;

        xa = {8'd0, 8'd5, 8'd0};
        xb = {8'd77, 8'd5, 8'd159};
        yb = {7'd33, 7'd0, 7'd119};
        cb = {3'd6, 3'd0, 3'd2};

        // eng_en=101: slot 1 skipped, foreign plots ignored, eng_en change after
        // latch ignored, start dropped mid-run so done pulses for one cycle.
        tbl[0]  = '{1'b1, 3'b101, 3'b000, 3'b000, xa, 21'd0, 9'd0, 3'b000, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0};
        tbl[1]  = '{1'b1, 3'b101, 3'b000, 3'b000, xa, 21'd0, 9'd0, 3'b001, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0};
        tbl[2]  = '{1'b1, 3'b101, 3'b000, 3'b110, xa, 21'd0, 9'd0, 3'b001, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0};
        tbl[3]  = '{1'b1, 3'b101, 3'b000, 3'b001, xb, yb,    cb,   3'b001, 1'b0, 1'b1, 8'd159, 7'd119, 3'd2};
        tbl[4]  = '{1'b1, 3'b101, 3'b001, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd159, 7'd119, 3'd2};
        tbl[5]  = '{1'b1, 3'b010, 3'b001, 3'b001, xb, yb,    cb,   3'b000, 1'b0, 1'b1, 8'd159, 7'd119, 3'd2};
        tbl[6]  = '{1'b1, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd159, 7'd119, 3'd2};
        tbl[7]  = '{1'b1, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b100, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[8]  = '{1'b0, 3'b010, 3'b010, 3'b010, xb, yb,    cb,   3'b100, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[9]  = '{1'b0, 3'b010, 3'b100, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[10] = '{1'b0, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[11] = '{1'b0, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b000, 1'b1, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[12] = '{1'b0, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};
        tbl[13] = '{1'b0, 3'b010, 3'b000, 3'b000, xb, yb,    cb,   3'b000, 1'b0, 1'b0, 8'd77,  7'd33,  3'd6};

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();

        for (int i = 0; i < 14; i++) begin
            start      = tbl[i].start;
            eng_en     = tbl[i].en;
            tb_done    = tbl[i].edn;
            tb_plot    = tbl[i].epl;
            eng_x      = tbl[i].ex;
            eng_y      = tbl[i].ey;
            eng_colour = tbl[i].ec;
            @(posedge clk);
            #1;
            chk($sformatf("step%0d_est", i),  32'(eng_start),  32'(tbl[i].x_est));
            chk($sformatf("step%0d_done", i), 32'(done),       32'(tbl[i].x_done));
            chk($sformatf("step%0d_plot", i), 32'(vga_plot),   32'(tbl[i].x_plot));
            chk($sformatf("step%0d_x", i),    32'(vga_x),      32'(tbl[i].x_vx));
            chk($sformatf("step%0d_y", i),    32'(vga_y),      32'(tbl[i].x_vy));
            chk($sformatf("step%0d_col", i),  32'(vga_colour), 32'(tbl[i].x_vc));
            chk($sformatf("step%0d_err", i),  32'(err),        0);
        end

        // Empty mask: done two edges after start, no relaunch while start held.
        do_reset();
        start = 1'b1;
        eng_en = 3'b000;
        @(posedge clk);
        #1;
        chk("empty_done_early", 32'(done), 0);
        @(posedge clk);
        #1;
        chk("empty_done", 32'(done), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("empty_hold_done", 32'(done), 1);
            chk("empty_hold_est", 32'(eng_start), 0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("empty_done_drop", 32'(done), 0);

        // Async reset in the middle of slot 1, then restart from slot 0.
        do_reset();
        start = 1'b1;
        eng_en = 3'b011;
        wait_est(3'b001, 5, "rstrun_launch0");
        tb_done = 3'b001;
        wait_est(3'b000, 5, "rstrun_release0");
        tb_done = 3'b000;
        wait_est(3'b010, 5, "rstrun_launch1");
        tb_plot = 3'b010;
        eng_x = {8'd0, 8'd200, 8'd0};
        @(posedge clk);
        #1;
        chk("rstrun_plot", 32'(vga_plot), 1);
        chk("rstrun_x", 32'(vga_x), 200);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rstrun_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_plot = 3'b000;
        @(posedge clk);
        #1;
        chk("restart_launch_edge", 32'(eng_start), 0);
        @(posedge clk);
        #1;
        chk("restart_slot0", 32'(eng_start), 3'b001);

        // Slot 1 never finishes.
        do_reset();
        start = 1'b1;
        eng_en = 3'b111;
        wait_est(3'b001, 5, "hang_launch0");
        tb_done = 3'b001;
        wait_est(3'b000, 5, "hang_release0");
        tb_done = 3'b000;
        wait_est(3'b010, 5, "hang_launch1");
`ifdef DRAW_SEQ_WDOG_EN
        repeat (99) @(posedge clk);
        #1;
        chk("wdog_err_before", 32'(err), 0);
        @(posedge clk);
        #1;
        chk("wdog_err", 32'(err), 1);
        chk("wdog_est_drop", 32'(eng_start), 0);
        wait_est(3'b100, 10, "wdog_launch2");
        tb_done = 3'b100;
        wait_est(3'b000, 5, "wdog_release2");
        tb_done = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (done) found = 1'b1;
        end
        chk("wdog_done", 32'(found), 1);
        chk("wdog_err_sticky", 32'(err), 1);
`else
        repeat (150) @(posedge clk);
        #1;
        chk("hang_still_run", 32'(eng_start), 3'b010);
        chk("hang_err", 32'(err), 0);
        chk("hang_done", 32'(done), 0);
`endif

        // Full run with behavioural engines, all slots enabled.
        do_reset();
        use_beh = 1'b1;
        rises.delete();
        mon_on = 1'b1;
        start = 1'b1;
        eng_en = 3'b111;
        found = 1'b0;
        for (int k = 0; k < 25000 && !found; k++) begin
            @(posedge clk);
            #1;
            if (done) found = 1'b1;
        end
        chk("full_done", 32'(found), 1);
        chk("full_launches", 32'(rises.size()), 3);
        if (rises.size() == 3) begin
            chk("full_order0", 32'(rises[0]), 3'b001);
            chk("full_order1", 32'(rises[1]), 3'b010);
            chk("full_order2", 32'(rises[2]), 3'b100);
        end
        chk("full_plot_count", 32'(vga_cnt), 4833);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("full_done_drop", 32'(done), 0);
        mon_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
